// File: rtl/transfer_engine_p.sv
// ---------------------------------------------------------------------------
// transfer_engine_p
//   Small word memory with two operations:
//     LOAD   - streams DEPTH words from a into the memory, one per cycle, and
//              pulses load_done on the cycle that writes the last word.
//     GATHER - picks bit bit_sel out of every word and assembles a DEPTH-bit
//              result, one lane of LPW words per cycle. Disabled lanes
//              contribute all ones. The finished result is published on out
//              together with a one-cycle out_valid pulse.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-low reset
//   a          in   [DATA_W]   load data word
//   rd         in   load request (sampled in IDLE only, wins over wr)
//   wr         in   gather request (sampled in IDLE only)
//   lane_en    in   [LANES]    per-lane enable, latched when wr is accepted
//   bit_sel    in   [BSW]      bit index, latched when wr is accepted
//   out        out  [DEPTH]    gathered result, changes only on completion
//   out_valid  out  one-cycle pulse marking a new out value
//   load_done  out  one-cycle pulse marking load completion
//   busy       out  high whenever the engine is not IDLE
// ---------------------------------------------------------------------------
module transfer_engine_p #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int LANES  = 4,
    localparam int BSW   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic              rd,
    input  logic              wr,
    input  logic [LANES-1:0]  lane_en,
    input  logic [BSW-1:0]    bit_sel,
    output logic [DEPTH-1:0]  out,
    output logic              out_valid,
    output logic              load_done,
    output logic              busy
);

    localparam int LPW = DEPTH / LANES;
    localparam int PW  = $clog2(DEPTH);
    localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_GATHER = 2'd2
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [PW-1:0]      r_ptr;
    logic [LCW-1:0]     r_lane_cnt;
    logic [LANES-1:0]   r_lane_en;
    logic [BSW-1:0]     r_bit_sel;
    logic [DEPTH-1:0]   r_shadow;
    logic [DEPTH-1:0]   w_shadow_next;

    // Shadow result with the lane selected by r_lane_cnt replaced by this
    // cycle's gathered bits. On the final lane this is the complete result,
    // which lets out be loaded in the same edge without an extra cycle.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        w_shadow_next = r_shadow;
        for (int k = 0; k < LANES; k++) begin
            if (LCW'(k) == r_lane_cnt) begin
                for (int j = 0; j < LPW; j++) begin
                    w_shadow_next[k*LPW + j] = r_lane_en[k]
                                             ? r_mem[k*LPW + j][r_bit_sel]
                                             : 1'b1;
                end
            end
        end
    end

    assign busy = (r_state != S_IDLE);

    // NOTE: all state uses non-blocking assignments so every register sees
    // the values from before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            // NOTE: the memory is cleared by reset because a gather without
            // a prior load must read zeros; this forces flops, not a RAM.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_ptr      <= '0;
            r_lane_cnt <= '0;
            r_lane_en  <= '0;
            r_bit_sel  <= '0;
            r_shadow   <= '1;
            out        <= '1;
            out_valid  <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            load_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // rd has priority; a simultaneous wr is simply dropped.
                    if (rd) begin
                        r_state <= S_LOAD;
                        r_ptr   <= '0;
                    end else if (wr) begin
                        r_state    <= S_GATHER;
                        r_lane_cnt <= '0;
                        r_lane_en  <= lane_en;
                        r_bit_sel  <= bit_sel;
                    end
                end

                S_LOAD: begin
                    r_mem[r_ptr] <= a;
                    r_ptr        <= r_ptr + PW'(1);
                    if (r_ptr == PW'(DEPTH - 1)) begin
                        r_state   <= S_IDLE;
                        load_done <= 1'b1;
                    end
                end

                S_GATHER: begin
                    r_shadow   <= w_shadow_next;
                    r_lane_cnt <= r_lane_cnt + LCW'(1);
                    if (r_lane_cnt == LCW'(LANES - 1)) begin
                        out       <= w_shadow_next;
                        out_valid <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transfer_engine_p.sv
// ---------------------------------------------------------------------------
// tb_transfer_engine_p
//   Self-checking bench for transfer_engine_p at default parameters.
//   The reference model holds the memory contents as a plain array and
//   computes each gather result directly from the word/bit/lane rules.
// ---------------------------------------------------------------------------
module tb_transfer_engine_p;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int LANES  = 4;
    localparam int LPW    = DEPTH / LANES;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] a;
    logic              rd;
    logic              wr;
    logic [LANES-1:0]  lane_en;
    logic [3:0]        bit_sel;
    logic [DEPTH-1:0]  out;
    logic              out_valid;
    logic              load_done;
    logic              busy;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DEPTH-1:0]  model_out;

    transfer_engine_p #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .LANES (LANES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .rd       (rd),
        .wr       (wr),
        .lane_en  (lane_en),
        .bit_sel  (bit_sel),
        .out      (out),
        .out_valid(out_valid),
        .load_done(load_done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DEPTH-1:0] model_gather(input logic [3:0] bs,
                                                      input logic [LANES-1:0] le);
        logic [DEPTH-1:0] r;
        for (int i = 0; i < DEPTH; i++) begin
            r[i] = le[i / LPW] ? model_mem[i][bs] : 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_out = '1;
    endtask

    // Full load of 16 words. Optional noise toggles rd/wr during LOAD;
    // with_wr raises wr together with rd at acceptance.
    task automatic run_load(input logic [DATA_W-1:0] w [DEPTH], input bit with_wr,
                            input bit noise, input string tag);
        @(negedge clk);
        rd = 1'b1;
        wr = with_wr;
        lane_en = 4'hF;
        bit_sel = 4'd0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_on_accept: got %b want 1", tag, busy);
        end
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            a  = w[k];
            rd = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            wr = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            total++;
            if (load_done !== (k == DEPTH - 1)) begin
                bad++;
                $display("FAIL %s load_done cycle %0d: got %b want %b",
                         tag, k + 1, load_done, (k == DEPTH - 1));
            end
            total++;
            if (out_valid !== 1'b0 || out !== model_out) begin
                bad++;
                $display("FAIL %s out_during_load cycle %0d: got %h/%b want %h/0",
                         tag, k + 1, out, out_valid, model_out);
            end
        end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = w[i];
        @(negedge clk);
        rd = 1'b0;
        wr = 1'b0;
        // Any request seen during LOAD (or a dropped wr) must not have
        // started a gather: engine idle, no pulse.
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after_load: got busy=%b valid=%b want 0/0",
                     tag, busy, out_valid);
        end
    endtask

    // Gather; result expected exactly LANES edges after acceptance.
    task automatic run_gather(input logic [3:0] bs, input logic [LANES-1:0] le,
                              input bit noise, input string tag);
        logic [DEPTH-1:0] expv;
        expv = model_gather(bs, le);
        @(negedge clk);
        wr = 1'b1;
        rd = 1'b0;
        bit_sel = bs;
        lane_en = le;
        @(posedge clk);
        for (int c = 1; c <= LANES; c++) begin
            @(negedge clk);
            rd = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            wr = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                bit_sel = 4'($urandom);
                lane_en = 4'($urandom);
            end
            @(posedge clk); #1;
            total++;
            if (out_valid !== (c == LANES)) begin
                bad++;
                $display("FAIL %s out_valid edge %0d: got %b want %b",
                         tag, c, out_valid, (c == LANES));
            end
            total++;
            if (out !== ((c == LANES) ? expv : model_out)) begin
                bad++;
                $display("FAIL %s out edge %0d: got %h want %h",
                         tag, c, out, (c == LANES) ? expv : model_out);
            end
            total++;
            if (busy !== (c < LANES) || load_done !== 1'b0) begin
                bad++;
                $display("FAIL %s busy/load_done edge %0d: got %b/%b want %b/0",
                         tag, c, busy, load_done, (c < LANES));
            end
        end
        model_out = expv;
        @(negedge clk);
        rd = 1'b0;
        wr = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out !== model_out) begin
            bad++;
            $display("FAIL %s after_gather: got valid=%b busy=%b out=%h want 0/0/%h",
                     tag, out_valid, busy, out, model_out);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        total++;
        if (out !== 16'hFFFF) begin
            bad++;
            $display("FAIL reset_out: got %h want ffff", out);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if (load_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_load_done: got %b want 0", load_done);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_gather_no_load();
        // Memory holds reset contents; enabled lanes give zeros.
        run_gather(4'd5, 4'b0110, 1'b0, "gather_no_load");
    endtask

    task automatic test_counting_load();
        logic [DATA_W-1:0] w [DEPTH];
        for (int k = 0; k < DEPTH; k++) w[k] = DATA_W'(k);
        run_load(w, 1'b0, 1'b0, "count_load");
        if (model_gather(4'd0, 4'hF) !== 16'hAAAA)
            $display("note: model disagrees with 16'hAAAA");
        run_gather(4'd0, 4'hF, 1'b0, "count_bit0_all");
        run_gather(4'd0, 4'b0101, 1'b0, "count_bit0_0101");
        total++;
        if (out !== 16'hFAFA) begin
            bad++;
            $display("FAIL count_fafa_const: got %h want fafa", out);
        end
    endtask

    task automatic test_msb_words();
        logic [DATA_W-1:0] w [DEPTH];
        for (int k = 0; k < DEPTH; k++) w[k] = 16'h8000;
        run_load(w, 1'b0, 1'b0, "msb_load");
        run_gather(4'd15, 4'hF, 1'b0, "msb_bit15");
        total++;
        if (out !== 16'hFFFF) begin
            bad++;
            $display("FAIL msb_bit15_const: got %h want ffff", out);
        end
        run_gather(4'd3, 4'hF, 1'b0, "msb_bit3");
        total++;
        if (out !== 16'h0000) begin
            bad++;
            $display("FAIL msb_bit3_const: got %h want 0000", out);
        end
        run_gather(4'd3, 4'h0, 1'b0, "msb_no_lanes");
        total++;
        if (out !== 16'hFFFF) begin
            bad++;
            $display("FAIL no_lanes_const: got %h want ffff", out);
        end
    endtask

    task automatic test_rd_wr_priority();
        logic [DATA_W-1:0] w [DEPTH];
        for (int k = 0; k < DEPTH; k++) w[k] = 16'($urandom);
        run_load(w, 1'b1, 1'b1, "rd_wr_both");
    endtask

    task automatic test_reset_mid_gather();
        @(negedge clk);
        wr = 1'b1;
        bit_sel = 4'd0;
        lane_en = 4'hF;
        @(posedge clk);          // accepted
        @(negedge clk);
        wr = 1'b0;
        @(posedge clk);          // first gather cycle
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;      // second gather cycle replaced by reset
        model_reset();
        total++;
        if (out !== 16'hFFFF || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_gather: got out=%h valid=%b busy=%b want ffff/0/0",
                     out, out_valid, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0 || out !== 16'hFFFF) begin
                bad++;
                $display("FAIL rst_mid_gather_quiet %0d: got %h/%b want ffff/0",
                         c, out, out_valid);
            end
        end
        run_gather(4'd0, 4'hF, 1'b0, "post_rst_gather");
        total++;
        if (out !== 16'h0000) begin
            bad++;
            $display("FAIL post_rst_const: got %h want 0000", out);
        end
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        rd = 1'b1;
        a  = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < DEPTH; c++) begin
            @(posedge clk); #1;
            total++;
            if (load_done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid_load %0d: got done=%b busy=%b want 0/0",
                         c, load_done, busy);
            end
        end
        // Memory must read zeros again, including the words written pre-reset.
        run_gather(4'd7, 4'hF, 1'b0, "rst_mid_load_mem");
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] w [DEPTH];
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < DEPTH; k++) w[k] = 16'($urandom);
            run_load(w, 1'($urandom_range(0, 1)), 1'b1, "rand_load");
            for (int g = 0; g < 3; g++) begin
                run_gather(4'($urandom), 4'($urandom), 1'b1, "rand_gather");
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        a = '0;
        rd = 1'b0;
        wr = 1'b0;
        lane_en = '0;
        bit_sel = '0;
        model_reset();
        test_reset();
        test_gather_no_load();
        test_counting_load();
        test_msb_words();
        test_rd_wr_priority();
        test_reset_mid_gather();
        test_reset_mid_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
